// File: rtl/ser40_tx_scheduler.sv
// ser40_tx_scheduler
// Round-robin scheduler sharing one byte-to-serial shifter between NUM_REQ
// byte requesters. One byte is accepted per frame (valid/ready), the shifter
// is parallel-loaded with a one-cycle ser_load pulse, then shifts for 8
// cycles, optionally followed by GAP_CYCLES idle cycles.
//
// Ports:
//   clock_40   in   1          40 MHz clock, rising edge
//   reset      in   1          synchronous, active-high
//   req_valid  in   NUM_REQ    per-requester byte available
//   req_data   in   NUM_REQ*8  requester i byte at [8i+7:8i]
//   req_ready  out  NUM_REQ    one-hot accept strobe (combinational, IDLE only)
//   ser_data   out  8          byte presented to the shifter (registered)
//   ser_load   out  1          shifter load pulse (registered)
//   ser_frame  out  1          shifter serial output carries a valid bit
//   cur_id     out  3          requester owning the current frame
//   busy       out  1          scheduler is in LOAD, SHIFT or GAP
module ser40_tx_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int GAP_CYCLES = 0
) (
  input  logic                 clock_40,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*8-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           ser_data,
  output logic                 ser_load,
  output logic                 ser_frame,
  output logic [2:0]           cur_id,
  output logic                 busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  // Last value of the gap counter; only meaningful when GAP_CYCLES > 0.
  localparam logic [3:0] GAP_LAST = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;
  localparam logic [2:0] LAST_REQ = 3'(NUM_REQ - 1);

  state_t     state_q,     state_d;
  logic [2:0] bit_cnt_q,   bit_cnt_d;
  logic [3:0] gap_cnt_q,   gap_cnt_d;
  logic [2:0] ptr_q,       ptr_d;
  logic [7:0] ser_data_q,  ser_data_d;
  logic       ser_load_q,  ser_load_d;
  logic       ser_frame_q, ser_frame_d;
  logic [2:0] cur_id_q,    cur_id_d;

  logic       found_s;
  logic [2:0] winner_s;
  logic [7:0] win_byte_s;

  // Round-robin search: first valid requester at or above the pointer, wrapping.
  always_comb begin
    found_s  = 1'b0;
    winner_s = 3'd0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found_s && (i == ((int'(ptr_q) + k) % NUM_REQ)) && req_valid[i]) begin
          found_s  = 1'b1;
          winner_s = 3'(i);
        end else begin
          found_s  = found_s;
        end
      end
    end
  end

  // Select the winner's byte and form the one-hot ready strobe.
  always_comb begin
    win_byte_s = 8'd0;
    req_ready  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (int'(winner_s) == i) begin
        win_byte_s   = req_data[i*8 +: 8];
        req_ready[i] = (state_q == ST_IDLE) && found_s;
      end else begin
        req_ready[i] = 1'b0;
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    ptr_d       = ptr_q;
    ser_data_d  = ser_data_q;
    cur_id_d    = cur_id_q;
    ser_load_d  = 1'b0;
    // The shifter's output is registered, so delaying SHIFT by one cycle
    // lines the flag up with the serial bits (load cycle +2 .. +9).
    ser_frame_d = (state_q == ST_SHIFT);
    case (state_q)
      ST_IDLE: begin
        if (found_s) begin
          ser_data_d = win_byte_s;
          cur_id_d   = winner_s;
          ptr_d      = (winner_s == LAST_REQ) ? 3'd0 : (winner_s + 3'd1);
          ser_load_d = 1'b1;
          state_d    = ST_LOAD;
        end else begin
          state_d    = ST_IDLE;
        end
      end
      ST_LOAD: begin
        bit_cnt_d = 3'd0;
        state_d   = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (bit_cnt_q == 3'd7) begin
          bit_cnt_d = 3'd0;
          gap_cnt_d = 4'd0;
          state_d   = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
        end else begin
          bit_cnt_d = bit_cnt_q + 3'd1;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          gap_cnt_d = 4'd0;
          state_d   = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any frame in progress.
  always_ff @(posedge clock_40) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd0;
      gap_cnt_q   <= 4'd0;
      ptr_q       <= 3'd0;
      ser_data_q  <= 8'd0;
      ser_load_q  <= 1'b0;
      ser_frame_q <= 1'b0;
      cur_id_q    <= 3'd0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      ptr_q       <= ptr_d;
      ser_data_q  <= ser_data_d;
      ser_load_q  <= ser_load_d;
      ser_frame_q <= ser_frame_d;
      cur_id_q    <= cur_id_d;
    end
  end

  assign ser_data  = ser_data_q;
  assign ser_load  = ser_load_q;
  assign ser_frame = ser_frame_q;
  assign cur_id    = cur_id_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ser40_tx_scheduler.sv
// Self-checking bench for ser40_tx_scheduler: one instance with no gap and one
// with a 3-cycle gap share the same requester stimulus. A transaction-level
// model (accept time, round-robin pointer, frame windows) predicts every output.
module tb_ser40_tx_scheduler;

  logic             clk = 1'b0;
  logic             reset;
  logic [3:0]       req_valid;
  logic [31:0]      req_data;
  logic [1:0][3:0]  rdy;
  logic [1:0][7:0]  sdat;
  logic [1:0]       sload;
  logic [1:0]       sframe;
  logic [1:0][2:0]  cid;
  logic [1:0]       sbusy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Transaction-level reference state per instance.
  int         m_acc  [2];
  int         m_prev [2];
  int         m_ptr  [2];
  int         m_id   [2];
  logic [7:0] m_byte [2];

  int lq0[$];
  int lq1[$];
  int iq0[$];

  // Behavioural shifter attached to the gapless instance.
  logic [7:0] sr;
  logic       sout;
  int         nbits;
  logic [7:0] rxbyte;

  always #5 clk = ~clk;

  ser40_tx_scheduler #(.NUM_REQ(4), .GAP_CYCLES(0)) dut0 (
    .clock_40 (clk),       .reset    (reset),
    .req_valid(req_valid), .req_data (req_data),
    .req_ready(rdy[0]),    .ser_data (sdat[0]),
    .ser_load (sload[0]),  .ser_frame(sframe[0]),
    .cur_id   (cid[0]),    .busy     (sbusy[0])
  );

  ser40_tx_scheduler #(.NUM_REQ(4), .GAP_CYCLES(3)) dut3 (
    .clock_40 (clk),       .reset    (reset),
    .req_valid(req_valid), .req_data (req_data),
    .req_ready(rdy[1]),    .ser_data (sdat[1]),
    .ser_load (sload[1]),  .ser_frame(sframe[1]),
    .cur_id   (cid[1]),    .busy     (sbusy[1])
  );

  always @(posedge clk) begin
    if (sload[0]) begin
      sr <= sdat[0];
    end else begin
      sout <= sr[0];
      sr   <= {1'b0, sr[7:1]};
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit in_frame(input int t, input int acc);
    return (t >= acc + 3) && (t <= acc + 10);
  endfunction

  task automatic model_cycle(input int u, input logic [3:0] v, input logic [31:0] d, input logic rst);
    int g;
    int w;
    logic [3:0] er;
    g = (u == 0) ? 0 : 3;
    if (rst) begin
      m_acc[u]  = -1000;
      m_prev[u] = -1000;
      m_ptr[u]  = 0;
      m_id[u]   = 0;
      m_byte[u] = 8'h00;
    end else begin
      chk($sformatf("u%0d ser_load c%0d", u, cyc), 32'(sload[u]), 32'(cyc == m_acc[u] + 1));
      chk($sformatf("u%0d ser_frame c%0d", u, cyc), 32'(sframe[u]),
          32'(in_frame(cyc, m_acc[u]) || in_frame(cyc, m_prev[u])));
      chk($sformatf("u%0d busy c%0d", u, cyc), 32'(sbusy[u]),
          32'((cyc > m_acc[u]) && (cyc < m_acc[u] + 10 + g)));
      chk($sformatf("u%0d ser_data c%0d", u, cyc), 32'(sdat[u]), 32'(m_byte[u]));
      chk($sformatf("u%0d cur_id c%0d", u, cyc), 32'(cid[u]), 32'(m_id[u]));
      w = -1;
      if (cyc >= m_acc[u] + 10 + g) begin
        for (int k = 0; k < 4; k++) begin
          if (w < 0 && v[(m_ptr[u] + k) % 4]) w = (m_ptr[u] + k) % 4;
        end
      end
      er = (w >= 0) ? 4'(1 << w) : 4'b0000;
      chk($sformatf("u%0d req_ready c%0d", u, cyc), 32'(rdy[u]), 32'(er));
      if (w >= 0) begin
        m_prev[u] = m_acc[u];
        m_acc[u]  = cyc;
        m_ptr[u]  = (w + 1) % 4;
        m_id[u]   = w;
        m_byte[u] = d[w*8 +: 8];
      end
    end
  endtask

  task automatic step(input logic [3:0] v, input logic [31:0] d, input logic rst);
    @(negedge clk);
    req_valid = v;
    req_data  = d;
    reset     = rst;
    #1;
    if (sload[0] === 1'b1) begin
      lq0.push_back(cyc);
      iq0.push_back(int'(cid[0]));
    end
    if (sload[1] === 1'b1) lq1.push_back(cyc);
    if (sframe[0] === 1'b1) begin
      if (nbits < 8) rxbyte[nbits] = sout;
      nbits++;
    end
    model_cycle(0, v, d, rst);
    model_cycle(1, v, d, rst);
    cyc++;
  endtask

  task automatic clear_logs();
    lq0.delete();
    lq1.delete();
    iq0.delete();
  endtask

  initial begin
    req_valid = 4'b0000;
    req_data  = 32'h0;
    reset     = 1'b1;
    nbits     = 0;
    rxbyte    = 8'h00;

    // Reset, then one idle cycle showing reset values.
    step(4'b0000, 32'h0, 1'b1);
    step(4'b0000, 32'h0, 1'b1);
    step(4'b0000, 32'h0, 1'b0);

    // Single request from requester 0 carrying 0xA5.
    nbits  = 0;
    rxbyte = 8'h00;
    step(4'b0001, 32'h000000A5, 1'b0);
    for (int i = 0; i < 14; i++) step(4'b0000, 32'h000000A5, 1'b0);
    chk("single nbits", 32'(nbits), 32'd8);
    chk("single serial", 32'(rxbyte), 32'h000000A5);

    // All requesters valid continuously from a fresh reset.
    step(4'b0000, 32'h0, 1'b1);
    clear_logs();
    for (int i = 0; i < 45; i++) step(4'b1111, 32'h44332211, 1'b0);
    chk("allv n0", 32'(lq0.size()), 32'd5);
    chk("allv n3", 32'(lq1.size()), 32'd4);
    for (int i = 1; i < 5 && i < lq0.size(); i++)
      chk($sformatf("allv period0 %0d", i), 32'(lq0[i] - lq0[i-1]), 32'd10);
    for (int i = 1; i < 4 && i < lq1.size(); i++)
      chk($sformatf("allv period3 %0d", i), 32'(lq1[i] - lq1[i-1]), 32'd13);
    for (int i = 0; i < 5 && i < iq0.size(); i++)
      chk($sformatf("allv order %0d", i), 32'(iq0[i]), 32'(i % 4));

    // Pointer wrap: grant 3, then only 3 and 1 valid.
    step(4'b0000, 32'h0, 1'b1);
    clear_logs();
    step(4'b1000, 32'hD4C3B2A1, 1'b0);
    for (int i = 0; i < 30; i++) step(4'b1010, 32'hD4C3B2A1, 1'b0);
    chk("wrap n", 32'(iq0.size()), 32'd3);
    for (int i = 0; i < 3 && i < iq0.size(); i++)
      chk($sformatf("wrap order %0d", i), 32'(iq0[i]), (i == 1) ? 32'd1 : 32'd3);

    // Reset while in SHIFT count 4 aborts the frame.
    step(4'b0000, 32'h0, 1'b1);
    step(4'b0001, 32'h0000005A, 1'b0);
    for (int i = 0; i < 5; i++) step(4'b0000, 32'h0, 1'b0);
    step(4'b0000, 32'h0, 1'b1);
    clear_logs();
    for (int i = 0; i < 15; i++) step(4'b0000, 32'h0, 1'b0);
    chk("abort loads", 32'(lq0.size() + lq1.size()), 32'd0);
    step(4'b0100, 32'h00770000, 1'b0);
    for (int i = 0; i < 3; i++) step(4'b0000, 32'h0, 1'b0);
    chk("post abort load", 32'(lq0.size()), 32'd1);

    // Requester 2 withdraws its valid during SHIFT.
    step(4'b0000, 32'h0, 1'b1);
    clear_logs();
    step(4'b0101, 32'h00660055, 1'b0);
    for (int i = 0; i < 4; i++) step(4'b0100, 32'h00660055, 1'b0);
    for (int i = 0; i < 15; i++) step(4'b0000, 32'h00660055, 1'b0);
    chk("withdraw loads", 32'(lq0.size()), 32'd1);
    chk("withdraw ready", 32'(rdy[0]), 32'd0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      step(4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)), $urandom(),
           1'($urandom_range(0, 59) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
